// File: rtl/pipeline_stage_de_divider.sv
// pipeline_stage_de_divider
//   DE-stage execution unit fed by the RE->DE pipeline register. Computes the
//   unsigned quotient and remainder of D / Q with a restoring shift-subtract
//   divider that resolves one quotient bit per cycle. While an operation
//   occupies the stage, o_stall holds the upstream register. The result is
//   offered downstream with a valid/stall handshake.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_valid        operand pair on i_D_value/i_Q_value is valid
//   i_D_value      dividend
//   i_Q_value      divisor
//   i_stall        downstream cannot accept the result this cycle
//   o_stall        hold RE->DE register (operands not accepted)
//   o_valid        result on o_quotient/o_remainder is valid
//   o_quotient     D / Q (all ones when Q == 0)
//   o_remainder    D % Q (D when Q == 0)
//   o_div_by_zero  result came from Q == 0
module pipeline_stage_de_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_D_value,
  input  logic [WIDTH-1:0] i_Q_value,
  input  logic             i_stall,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qsh;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] qsh_step;
  logic             last_bit;
  logic             q_is_zero;

  // One restoring-division step. The partial remainder is always below the
  // divisor, so the shifted value is below 2*Q and the MSB of the WIDTH+1 bit
  // difference is a clean borrow flag.
  always_comb begin
    shifted  = {acc, qsh[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    trial_ok = ~trial[WIDTH];
    acc_step = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    qsh_step = {qsh[WIDTH-2:0], trial_ok};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  assign q_is_zero = (i_Q_value == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          state_nxt = q_is_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!i_stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_stall = (state != IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      divisor       <= '0;
      acc           <= '0;
      qsh           <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            divisor <= i_Q_value;
            cnt     <= '0;
            acc     <= '0;
            qsh     <= i_D_value;
            if (q_is_zero) begin
              o_quotient    <= '1;
              o_remainder   <= i_D_value;
              o_div_by_zero <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc <= acc_step;
          qsh <= qsh_step;
          cnt <= cnt + 1'b1;
          // Result registers take the final step directly so they are valid
          // in the first DONE cycle.
          if (last_bit) begin
            o_quotient    <= qsh_step;
            o_remainder   <= acc_step;
            o_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stage_de_divider.sv
module tb_pipeline_stage_de_divider;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic [WIDTH-1:0] i_D;
  logic [WIDTH-1:0] i_Q;
  logic             i_stall;
  logic             o_stall;
  logic             o_valid;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_dbz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stage_de_divider #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .i_D_value    (i_D),
    .i_Q_value    (i_Q),
    .i_stall      (i_stall),
    .o_stall      (o_stall),
    .o_valid      (o_valid),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_dbz)
  );

  // Reference: plain arithmetic, with the divide-by-zero convention.
  function automatic void model(input logic [7:0] d, input logic [7:0] q,
                                output logic [7:0] eq, output logic [7:0] er,
                                output logic edbz);
    if (q == 0) begin
      eq = 8'hFF; er = d; edbz = 1'b1;
    end else begin
      eq = d / q; er = d % q; edbz = 1'b0;
    end
  endfunction

  // Issues one operation from IDLE and observes it until it leaves DONE.
  // Holds i_stall high for the first stall_n DONE cycles.
  task automatic run_op(input logic [7:0] d, input logic [7:0] q, input int stall_n,
                        output int busy, output int vcyc,
                        output logic [7:0] qo, output logic [7:0] ro, output logic dbz,
                        output bit stable, output bit timeout);
    int t;
    busy = 0; vcyc = 0; stable = 1; timeout = 0; t = 0;
    @(negedge clk);
    i_D = d; i_Q = q; i_valid = 1'b1; i_stall = (stall_n > 0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    // Operands are don't-care once accepted.
    i_D = 8'($urandom); i_Q = 8'($urandom);
    @(negedge clk);
    while (!o_valid && t < 40) begin
      if (o_stall) busy++;
      else stable = 0;
      t++;
      @(negedge clk);
    end
    if (t >= 40) timeout = 1;
    qo = o_quotient; ro = o_remainder; dbz = o_dbz;
    while (o_valid && vcyc < 40) begin
      vcyc++;
      if (o_quotient !== qo || o_remainder !== ro || o_dbz !== dbz || o_stall !== 1'b1)
        stable = 0;
      i_stall = (vcyc <= stall_n);
      @(negedge clk);
    end
    if (vcyc >= 40) timeout = 1;
    i_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 0; i_D = 8'hA5; i_Q = 8'h3C; i_stall = 0;
    #12;
    n_checks++;
    if ({o_stall, o_valid, o_quotient, o_remainder, o_dbz} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b valid=%b q=%0d r=%0d dbz=%b, want all 0",
               o_stall, o_valid, o_quotient, o_remainder, o_dbz);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got stall=%b valid=%b, want 0 0", o_stall, o_valid);
    end
  endtask

  task automatic test_basic();
    int busy, vcyc; logic [7:0] qo, ro; logic dbz; bit st, to;
    run_op(8'd200, 8'd7, 0, busy, vcyc, qo, ro, dbz, st, to);
    n_checks++;
    if (to || qo !== 8'd28 || ro !== 8'd4 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b to=%b, want q=28 r=4 dbz=0",
               qo, ro, dbz, to);
    end
    n_checks++;
    if (busy !== WIDTH || vcyc !== 1 || !st) begin
      n_fail++;
      $display("FAIL basic_timing: got busy=%0d valid_cycles=%0d stall_ok=%b, want %0d 1 1",
               busy, vcyc, st, WIDTH);
    end
    // Result holds after leaving DONE; stage back in IDLE.
    n_checks++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_quotient !== 8'd28 || o_remainder !== 8'd4) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b stall=%b q=%0d r=%0d, want 0 0 28 4",
               o_valid, o_stall, o_quotient, o_remainder);
    end
  endtask

  task automatic test_div_by_zero();
    int busy, vcyc; logic [7:0] qo, ro; logic dbz; bit st, to;
    run_op(8'd5, 8'd0, 0, busy, vcyc, qo, ro, dbz, st, to);
    n_checks++;
    if (to || qo !== 8'hFF || ro !== 8'd5 || dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_5_0: got q=%0h r=%0d dbz=%b, want q=ff r=5 dbz=1", qo, ro, dbz);
    end
    n_checks++;
    if (busy !== 0 || vcyc !== 1) begin
      n_fail++;
      $display("FAIL dbz_timing: got busy=%0d valid_cycles=%0d, want 0 1", busy, vcyc);
    end
  endtask

  task automatic test_corners();
    logic [7:0] dv [5] = '{8'd255, 8'd3, 8'd0, 8'd255, 8'd1};
    logic [7:0] qv [5] = '{8'd1, 8'd10, 8'd9, 8'd255, 8'd255};
    int busy, vcyc; logic [7:0] qo, ro, eq, er; logic dbz, edbz; bit st, to;
    for (int i = 0; i < 5; i++) begin
      run_op(dv[i], qv[i], 0, busy, vcyc, qo, ro, dbz, st, to);
      model(dv[i], qv[i], eq, er, edbz);
      n_checks++;
      if (to || qo !== eq || ro !== er || dbz !== edbz) begin
        n_fail++;
        $display("FAIL corner_%0d_%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                 dv[i], qv[i], qo, ro, dbz, eq, er, edbz);
      end
    end
  endtask

  task automatic test_random();
    int busy, vcyc; logic [7:0] d, q, qo, ro, eq, er; logic dbz, edbz; bit st, to;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      q = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(d, q, int'($urandom_range(0, 2)), busy, vcyc, qo, ro, dbz, st, to);
      model(d, q, eq, er, edbz);
      n_checks++;
      if (to || !st || qo !== eq || ro !== er || dbz !== edbz ||
          busy !== ((q == 0) ? 0 : WIDTH)) begin
        n_fail++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dbz=%b busy=%0d st=%b, want q=%0d r=%0d dbz=%b",
                 d, q, qo, ro, dbz, busy, st, eq, er, edbz);
      end
    end
  endtask

  task automatic test_stall();
    int busy, vcyc; logic [7:0] qo, ro; logic dbz; bit st, to;
    run_op(8'd200, 8'd7, 3, busy, vcyc, qo, ro, dbz, st, to);
    n_checks++;
    if (to || vcyc !== 4 || !st || qo !== 8'd28 || ro !== 8'd4) begin
      n_fail++;
      $display("FAIL stall_hold: got valid_cycles=%0d stable=%b q=%0d r=%0d, want 4 1 28 4",
               vcyc, st, qo, ro);
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b stall=%b, want 0 0", o_valid, o_stall);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen_valid = 0, seen_stall = 0;
    @(negedge clk);
    i_D = 8'd200; i_Q = 8'd7; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_stall, o_valid, o_quotient, o_remainder, o_dbz} !== '0) begin
      n_fail++;
      $display("FAIL midbusy_reset: got stall=%b valid=%b q=%0d r=%0d dbz=%b, want all 0",
               o_stall, o_valid, o_quotient, o_remainder, o_dbz);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) seen_valid = 1;
      if (o_stall) seen_stall = 1;
    end
    n_checks++;
    if (seen_valid || seen_stall) begin
      n_fail++;
      $display("FAIL midbusy_aborted: got valid_seen=%b stall_seen=%b, want 0 0",
               seen_valid, seen_stall);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, n_acc = 0;
    int acc_t [2];
    logic [7:0] rq [$];
    logic [7:0] rr [$];
    logic prev_v = 0;
    @(negedge clk);
    i_D = 8'd200; i_Q = 8'd7; i_valid = 1'b1;
    while (cyc < 40 && rq.size() < 2) begin
      if (o_valid && !prev_v) begin
        rq.push_back(o_quotient);
        rr.push_back(o_remainder);
      end
      prev_v = o_valid;
      if (!o_stall && i_valid) begin
        if (n_acc < 2) acc_t[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc == 1) begin
        i_D = 8'd100; i_Q = 8'd9;
      end else if (n_acc >= 2) begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    n_checks++;
    if (n_acc !== 2 || acc_t[1] - acc_t[0] !== WIDTH + 2) begin
      n_fail++;
      $display("FAIL b2b_period: got accepts=%0d period=%0d, want 2 %0d",
               n_acc, acc_t[1] - acc_t[0], WIDTH + 2);
    end
    n_checks++;
    if (rq.size() != 2 || rq[0] !== 8'd28 || rr[0] !== 8'd4 || rq[1] !== 8'd11 || rr[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_results: got %0d results, want 28/4 then 11/1", rq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_corners();
    test_stall();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
